// File: rtl/meas_sequencer_pkg.sv
// rtl/meas_sequencer_pkg.sv - shared state encoding and default widths for the measurement sequencer
package meas_sequencer_pkg;

    localparam int DEF_DATA_W    = 12;
    localparam int DEF_MAX_COUNT = 600;
    localparam int MISS_W        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/meas_sequencer_if.sv
// rtl/meas_sequencer_if.sv - control, echo, result and readback signals of the measurement sequencer
interface meas_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int DATA_W = 12
);
    logic              enable;
    logic              single_shot;
    logic              start;
    logic [DATA_W-1:0] raw_in;
    logic              echo_seen;
    logic [CH_W-1:0]   ch_sel;
    logic              tx_en;
    logic              busy;
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [DATA_W-1:0] res_data;
    logic [NUM_CH-1:0] fault;
    logic [CH_W-1:0]   rd_ch;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output enable, single_shot, start, raw_in, echo_seen, rd_ch,
        input  ch_sel, tx_en, busy, res_valid, res_ch, res_data, fault, rd_data
    );

    modport slave (
        input  enable, single_shot, start, raw_in, echo_seen, rd_ch,
        output ch_sel, tx_en, busy, res_valid, res_ch, res_data, fault, rd_data
    );

endinterface

// File: rtl/meas_next_ch.sv
// rtl/meas_next_ch.sv - finds the next eligible channel in this sweep, or the first one of the next sweep
module meas_next_ch #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] fault,
    input  logic [CH_W-1:0]   cur,
    input  logic              restart,
    input  logic              retry_cur,
    input  logic              retry_new,
    output logic              wrap,
    output logic              found,
    output logic [CH_W-1:0]   nxt
);

    logic [NUM_CH-1:0] elig_cur;
    logic [NUM_CH-1:0] elig_new;
    logic              start_ok;
    logic              above_ok;
    logic              first_ok;
    logic [CH_W-1:0]   start_idx;
    logic [CH_W-1:0]   above_idx;
    logic [CH_W-1:0]   first_idx;

    always_comb begin
        elig_cur  = ~fault | {NUM_CH{retry_cur}};
        elig_new  = ~fault | {NUM_CH{retry_new}};
        start_ok  = 1'b0;
        above_ok  = 1'b0;
        first_ok  = 1'b0;
        start_idx = '0;
        above_idx = '0;
        first_idx = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig_cur[i]) begin
                start_ok  = 1'b1;
                start_idx = CH_W'(i);
            end
            if (elig_cur[i] && (CH_W'(i) > cur)) begin
                above_ok  = 1'b1;
                above_idx = CH_W'(i);
            end
            if (elig_new[i]) begin
                first_ok  = 1'b1;
                first_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        wrap  = 1'b0;
        found = 1'b0;
        nxt   = '0;
        if (restart) begin
            found = start_ok;
            nxt   = start_idx;
        end else if (above_ok) begin
            found = 1'b1;
            nxt   = above_idx;
        end else begin
            wrap  = 1'b1;
            found = first_ok;
            nxt   = first_idx;
        end
    end

endmodule

// File: rtl/meas_sequencer.sv
// rtl/meas_sequencer.sv - round-robin ranging frame sequencer; MEAS_SEQ_AVG_EN enables result averaging
module meas_sequencer
    import meas_sequencer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_COUNT    = DEF_MAX_COUNT,
    parameter int MISS_LIMIT   = 3,
    parameter int RETRY_SWEEPS = 4
) (
    input logic             clk_34,
    input logic             reset,
    meas_sequencer_if.slave bus
);

    localparam int SW_W = $clog2(RETRY_SWEEPS);

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   ch_sel;
    logic [CH_W-1:0]   ch_sel_nxt;
    logic              tx_en;
    logic              tx_en_nxt;
    logic              res_valid;
    logic [CH_W-1:0]   res_ch;
    logic [DATA_W-1:0] res_data;
    logic [NUM_CH-1:0] fault;
    logic [NUM_CH-1:0] fault_nxt;
    logic [DATA_W-1:0] store [NUM_CH];
    logic [MISS_W-1:0] miss  [NUM_CH];
    logic [SW_W-1:0]   sweep_cnt;
    logic [SW_W-1:0]   sweep_inc;
    logic              sweep_adv;
    logic              cap;
    logic              good;
    logic [MISS_W-1:0] miss_inc;
    logic [DATA_W-1:0] store_val;
    logic              nc_wrap;
    logic              nc_found;
    logic [CH_W-1:0]   nc_idx;

    // A frame is only captured when it was fully stimulated and enable is still high.
    assign cap       = (state == RUN) && tx_en && bus.enable;
    assign good      = bus.echo_seen && (bus.raw_in <= DATA_W'(MAX_COUNT));
    assign miss_inc  = (miss[ch_sel] == MISS_W'(MISS_LIMIT)) ? miss[ch_sel]
                                                              : miss[ch_sel] + MISS_W'(1);
    assign sweep_inc = (sweep_cnt == SW_W'(RETRY_SWEEPS - 1)) ? '0 : sweep_cnt + SW_W'(1);

`ifdef MEAS_SEQ_AVG_EN
    logic [NUM_CH-1:0] has_good;
    logic [DATA_W:0]   avg_sum;

    assign avg_sum   = {1'b0, bus.raw_in} + {1'b0, store[ch_sel]} + (DATA_W + 1)'(1);
    assign store_val = has_good[ch_sel] ? avg_sum[DATA_W:1] : bus.raw_in;

    always_ff @(posedge clk_34 or posedge reset) begin
        if (reset) begin
            has_good <= '0;
        end else if (cap && good) begin
            has_good[ch_sel] <= 1'b1;
        end
    end
`else
    assign store_val = bus.raw_in;
`endif

    always_comb begin
        fault_nxt = fault;
        if (cap) begin
            if (good) begin
                fault_nxt[ch_sel] = 1'b0;
            end else if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                fault_nxt[ch_sel] = 1'b1;
            end
        end
    end

    // Eligibility uses this frame's fault update so a just-faulted channel is not revisited.
    meas_next_ch #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_next_ch (
        .fault     (fault_nxt),
        .cur       (ch_sel),
        .restart   (state == IDLE),
        .retry_cur (sweep_cnt == '0),
        .retry_new (sweep_inc == '0),
        .wrap      (nc_wrap),
        .found     (nc_found),
        .nxt       (nc_idx)
    );

    always_ff @(posedge clk_34 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ch_sel_nxt = ch_sel;
        tx_en_nxt  = tx_en;
        sweep_adv  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable && (bus.start || !bus.single_shot)) begin
                    ch_sel_nxt = nc_found ? nc_idx : ch_sel;
                    tx_en_nxt  = nc_found;
                    state_nxt  = nc_found ? PRIME : RUN;
                end
            end
            PRIME: begin
                if (!bus.enable) begin
                    state_nxt = IDLE;
                    tx_en_nxt = 1'b0;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_nxt = IDLE;
                    tx_en_nxt = 1'b0;
                end else if (!nc_wrap) begin
                    ch_sel_nxt = nc_idx;
                    tx_en_nxt  = 1'b1;
                end else begin
                    sweep_adv = 1'b1;
                    if (bus.single_shot) begin
                        state_nxt = IDLE;
                        tx_en_nxt = 1'b0;
                    end else if (nc_found) begin
                        ch_sel_nxt = nc_idx;
                        tx_en_nxt  = 1'b1;
                    end else begin
                        tx_en_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_34 or posedge reset) begin
        if (reset) begin
            ch_sel    <= '0;
            tx_en     <= 1'b0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            fault     <= '0;
            sweep_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                store[i] <= '0;
                miss[i]  <= '0;
            end
        end else begin
            ch_sel    <= ch_sel_nxt;
            tx_en     <= tx_en_nxt;
            res_valid <= cap && good;
            fault     <= fault_nxt;
            if (sweep_adv) begin
                sweep_cnt <= sweep_inc;
            end
            if (cap) begin
                if (good) begin
                    store[ch_sel] <= store_val;
                    miss[ch_sel]  <= '0;
                    res_ch        <= ch_sel;
                    res_data      <= store_val;
                end else begin
                    miss[ch_sel]  <= miss_inc;
                end
            end
        end
    end

    assign bus.ch_sel    = ch_sel;
    assign bus.tx_en     = tx_en;
    assign bus.busy      = (state != IDLE);
    assign bus.res_valid = res_valid;
    assign bus.res_ch    = res_ch;
    assign bus.res_data  = res_data;
    assign bus.fault     = fault;
    assign bus.rd_data   = store[bus.rd_ch];

endmodule

// File: doc/meas_sequencer.md
Name: meas_sequencer

Overview:
- Frame-rate controller for the ultrasonic ranging datapath; one clk_34 period is one measurement frame.
- Round-robin schedules the stimulus/echo path across NUM_CH transducers, captures the echo counter at each frame boundary, range-checks it, and stores a per-channel result.
- Tracks consecutive misses per channel, marks faulty channels and skips them except on periodic retry sweeps.
- Sits between the counter/filter and the LED/readback logic; ch_sel and tx_en drive the transducer mux and stimulus gate.

Parameters:
- NUM_CH, 4, number of transducer channels (2..8)
- CH_W, 2, width of channel index, >= clog2(NUM_CH)
- DATA_W, 12, echo count width
- MAX_COUNT, 600, largest valid echo count; above this is a miss
- MISS_LIMIT, 3, consecutive misses that set a channel fault (1..15)
- RETRY_SWEEPS, 4, faulted channels are measured once every RETRY_SWEEPS sweeps (>= 2)

Ports:
- clk_34  in  1  frame clock
- reset  in  1  asynchronous, active-high
- enable  in  1  level; run permitted
- single_shot  in  1  level; 1 = one sweep per start, 0 = continuous
- start  in  1  sampled on clk_34; begins a single-shot sweep
- raw_in  in  DATA_W  echo counter value for the frame just ending
- echo_seen  in  1  echo detected during the frame just ending
- ch_sel  out  CH_W  channel driven this frame
- tx_en  out  1  stimulus gate for this frame
- busy  out  1  state != IDLE
- res_valid  out  1  one-frame pulse: new good result stored
- res_ch  out  CH_W  channel of res_data
- res_data  out  DATA_W  stored result
- fault  out  NUM_CH  per-channel fault flags
- rd_ch  in  CH_W  readback select
- rd_data  out  DATA_W  combinational read of result store[rd_ch]

Behaviour:
- Reset: state IDLE; ch_sel=0, tx_en=0, busy=0, res_valid=0, res_ch=0, res_data=0, fault=0, store=0, miss counters=0, sweep counter=0.
- States: IDLE, PRIME, RUN. All transitions on posedge clk_34.
- IDLE -> PRIME when enable & (start | !single_shot). PRIME: tx_en=1, ch_sel=first eligible channel; frame result at end of PRIME is discarded (partial frame), then RUN on same channel.
- RUN: at each edge, sample raw_in/echo_seen for current ch_sel, then advance.
- Good = echo_seen & raw_in <= MAX_COUNT (raw_in==MAX_COUNT is good). Good: store[c]<=raw_in, miss[c]<=0, fault[c]<=0, res_valid=1, res_ch=c, res_data=raw_in next frame.
- Miss: store unchanged, miss[c] saturating increment; fault[c] set when miss[c] reaches MISS_LIMIT.
- Eligible channel: fault clear, or current sweep is a retry sweep (sweep_cnt % RETRY_SWEEPS == 0). Advance = next eligible index above current in this sweep; if none, sweep_cnt++ and first eligible of new sweep; if none eligible, idle frame (tx_en=0, ch_sel held, no capture at its end).
- single_shot: after capture of last eligible channel of the sweep -> IDLE, tx_en=0.
- enable low in PRIME/RUN: capture at that edge is discarded, -> IDLE immediately.
- start while busy ignored. Fault set and clear in same frame impossible (single decision per frame).
- Asynchronous reset mid-frame aborts everything to reset values.

Optional Feature:
- MEAS_SEQ_AVG_EN defined: good result stores (raw_in + store[c] + 1) >> 1 (DATA_W+1-bit sum) when channel has a prior good result; first good result stored raw. res_data follows stored value.
- Undefined: store raw_in directly.

Decomposition:
- Shared package: state encoding (IDLE/PRIME/RUN), default MAX_COUNT, DATA_W.
- One sub-module natural: meas_next_ch (combinational next-eligible-channel finder from fault vector, current index, retry flag).

Test Plan:
- Reset, enable=1, single_shot=0, all echoes good raw_in=300 -> PRIME on ch0, then res_valid for ch0,1,2,3,0 on consecutive frames, res_data=300.
- ch2 echo_seen=0 for 3 visits -> fault[2]=1 after third; next sweeps ch_sel skips 2, visits 2 on sweep where sweep_cnt%4==0.
- Faulted ch2 returns raw_in=250 on retry visit -> fault[2]=0, store[2]=250, rd_ch=2 gives 250.
- raw_in=600 -> good; raw_in=601 -> miss, store unchanged.
- single_shot=1, start pulse -> one PRIME + 4 captures, busy drops, no further tx_en until next start; start while busy ignored.
- enable dropped mid-RUN -> next edge IDLE, tx_en=0, no res_valid; all faulted with non-retry sweep -> idle frames with tx_en=0.
